// File: rtl/chirp_sequencer.sv
// Per-chirp acquisition scheduler: aligns FIR samples to ADF ramps and ping-pongs full buffers to the FFT.
// Optional ramp watchdog with sticky ramp_timeout output: define CHIRP_SEQ_TIMEOUT_EN.
module chirp_sequencer #(
  parameter int SAMPLES_PER_CHIRP = 1024,
  parameter int SETTLE_SAMPLES    = 8,
  parameter int CHIRPS_PER_FRAME  = 16,
  parameter int TIMEOUT_CYCLES    = 100000,
  parameter int AW                = $clog2(SAMPLES_PER_CHIRP),
  parameter int CW                = $clog2(CHIRPS_PER_FRAME + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          adf_done,
  input  logic          ramp_start,
  input  logic          sample_valid,
  input  logic          proc_done,
  output logic          capture_en,
  output logic          wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic          proc_start,
  output logic          proc_sel,
  output logic [CW-1:0] chirp_idx,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun,
  output logic          short_chirp
`ifdef CHIRP_SEQ_TIMEOUT_EN
  ,
  output logic          ramp_timeout
`endif
);

  localparam int SW          = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADF,
    S_WAIT_RAMP,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  // With no settling samples a ramp goes straight to capture.
  localparam state_t S_ENTRY = (SETTLE_SAMPLES == 0) ? S_CAPTURE : S_SETTLE;

  state_t          state_q, state_d;
  logic            wr_sel_q, wr_sel_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]   chirp_idx_q, chirp_idx_d;
  logic [1:0]      full_q, full_d;
  logic            own_q, own_d;
  logic            proc_sel_q, proc_sel_d;
  logic            proc_start_q, proc_start_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;
  logic            short_chirp_q, short_chirp_d;
  logic [1:0]      clr_mask, full_clr, set_mask;
`ifdef CHIRP_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            ramp_timeout_q, ramp_timeout_d;
  logic            to_expired;
  assign to_expired = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  // A proc_done releases the FFT's half before any completion in the same cycle is recorded.
  assign clr_mask   = (proc_done && own_q) ? (2'b01 << proc_sel_q) : 2'b00;
  assign full_clr   = full_q & ~clr_mask;
  assign capture_en = (state_q == S_CAPTURE) && sample_valid && adf_done && !ramp_start;

  always_comb begin
    state_d       = state_q;
    wr_sel_d      = wr_sel_q;
    wr_addr_d     = wr_addr_q;
    settle_cnt_d  = settle_cnt_q;
    chirp_idx_d   = chirp_idx_q;
    overrun_d     = overrun_q;
    short_chirp_d = short_chirp_q;
    frame_done_d  = 1'b0;
    set_mask      = 2'b00;
`ifdef CHIRP_SEQ_TIMEOUT_EN
    ramp_timeout_d = ramp_timeout_q;
    to_cnt_d       = '0;
    if (state_q == S_WAIT_RAMP && !ramp_start && !to_expired)
      to_cnt_d = to_cnt_q + TW'(1);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_ADF;
          chirp_idx_d = '0;
        end
      end
      S_WAIT_ADF: begin
        if (adf_done) state_d = S_WAIT_RAMP;
      end
      S_WAIT_RAMP: begin
        if (!adf_done) begin
          state_d = S_WAIT_ADF;
        end else if (ramp_start) begin
          if (full_clr[wr_sel_q]) begin
            overrun_d = 1'b1;
          end else begin
            state_d      = S_ENTRY;
            wr_addr_d    = '0;
            settle_cnt_d = '0;
          end
        end
`ifdef CHIRP_SEQ_TIMEOUT_EN
        else if (to_expired) begin
          state_d        = S_WAIT_ADF;
          ramp_timeout_d = 1'b1;
        end
`endif
      end
      S_SETTLE, S_CAPTURE: begin
        if (!adf_done) begin
          state_d      = S_WAIT_ADF;
          wr_addr_d    = '0;
          settle_cnt_d = '0;
        end else if (ramp_start) begin
          short_chirp_d = 1'b1;
          state_d       = S_ENTRY;
          wr_addr_d     = '0;
          settle_cnt_d  = '0;
        end else if (state_q == S_SETTLE) begin
          if (sample_valid) begin
            if (settle_cnt_q == SW'(SETTLE_LAST)) begin
              state_d      = S_CAPTURE;
              settle_cnt_d = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + SW'(1);
            end
          end
        end else if (capture_en) begin
          wr_addr_d = wr_addr_q + AW'(1);
          if (wr_addr_q == AW'(SAMPLES_PER_CHIRP - 1)) begin
            set_mask[wr_sel_q] = 1'b1;
            wr_sel_d           = ~wr_sel_q;
            chirp_idx_d        = chirp_idx_q + CW'(1);
            if (chirp_idx_q == CW'(CHIRPS_PER_FRAME - 1)) begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = S_WAIT_RAMP;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FFT handoff: grant the oldest full half whenever the FFT is (or is becoming) free.
  always_comb begin
    full_d       = full_clr | set_mask;
    own_d        = own_q && !proc_done;
    proc_sel_d   = proc_sel_q;
    proc_start_d = 1'b0;
    if (!own_d && (|full_d)) begin
      proc_start_d = 1'b1;
      own_d        = 1'b1;
      proc_sel_d   = (&full_d) ? wr_sel_d : full_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_sel_q      <= 1'b0;
      wr_addr_q     <= '0;
      settle_cnt_q  <= '0;
      chirp_idx_q   <= '0;
      full_q        <= 2'b00;
      own_q         <= 1'b0;
      proc_sel_q    <= 1'b0;
      proc_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      short_chirp_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_sel_q      <= wr_sel_d;
      wr_addr_q     <= wr_addr_d;
      settle_cnt_q  <= settle_cnt_d;
      chirp_idx_q   <= chirp_idx_d;
      full_q        <= full_d;
      own_q         <= own_d;
      proc_sel_q    <= proc_sel_d;
      proc_start_q  <= proc_start_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      short_chirp_q <= short_chirp_d;
    end
  end

`ifdef CHIRP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q       <= '0;
      ramp_timeout_q <= 1'b0;
    end else begin
      to_cnt_q       <= to_cnt_d;
      ramp_timeout_q <= ramp_timeout_d;
    end
  end
  assign ramp_timeout = ramp_timeout_q;
`endif

  assign wr_sel      = wr_sel_q;
  assign wr_addr     = wr_addr_q;
  assign proc_start  = proc_start_q;
  assign proc_sel    = proc_sel_q;
  assign chirp_idx   = chirp_idx_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign short_chirp = short_chirp_q;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench for chirp_sequencer with 8 samples/chirp, 2 settle samples, 3 chirps/frame.
// Build with CHIRP_SEQ_TIMEOUT_EN defined to also exercise the ramp watchdog (TIMEOUT_CYCLES=50).
module tb_chirp_sequencer;
  localparam int SPC = 8;
  localparam int SET = 2;
  localparam int CPF = 3;
  localparam int TO  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       adf_done = 1'b0;
  logic       ramp_start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       proc_done = 1'b0;
  logic       capture_en, wr_sel, proc_start, proc_sel, frame_done, busy, overrun, short_chirp;
  logic [2:0] wr_addr;
  logic [1:0] chirp_idx;
`ifdef CHIRP_SEQ_TIMEOUT_EN
  logic       ramp_timeout;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  chirp_sequencer #(
    .SAMPLES_PER_CHIRP(SPC),
    .SETTLE_SAMPLES   (SET),
    .CHIRPS_PER_FRAME (CPF),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .adf_done    (adf_done),
    .ramp_start  (ramp_start),
    .sample_valid(sample_valid),
    .proc_done   (proc_done),
    .capture_en  (capture_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .proc_start  (proc_start),
    .proc_sel    (proc_sel),
    .chirp_idx   (chirp_idx),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun),
    .short_chirp (short_chirp)
`ifdef CHIRP_SEQ_TIMEOUT_EN
    ,
    .ramp_timeout(ramp_timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed unfinished run, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1ns later, well before the next rising edge.
  task automatic drive(input logic st, input logic sv, input logic rs, input logic pd);
    @(negedge clk);
    start        = st;
    sample_valid = sv;
    ramp_start   = rs;
    proc_done    = pd;
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    adf_done = 1'b0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic arm();
    drive(1, 0, 0, 0);
    adf_done = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  // One ramp then ten samples: two settle, eight captured to addresses 0..7.
  task automatic chirp(input logic pd_last, input string tag, input bit check);
    drive(0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 0, (k == 10) ? pd_last : 1'b0);
      if (check) begin
        chk({tag, "_cap_en"}, capture_en, (k >= 3) ? 1 : 0);
        if (k >= 3) chk({tag, "_wr_addr"}, wr_addr, k - 3);
      end
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_capture_en", capture_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_proc_start", proc_start, 0);
    chk("rst_proc_sel", proc_sel, 0);
    chk("rst_chirp_idx", chirp_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_short_chirp", short_chirp, 0);
`ifdef CHIRP_SEQ_TIMEOUT_EN
    chk("rst_ramp_timeout", ramp_timeout, 0);
`endif

    // Nominal chirp
    arm();
    chk("nom_busy", busy, 1);
    chirp(0, "nom", 1);
    drive(0, 0, 0, 0);
    chk("nom_proc_start", proc_start, 1);
    chk("nom_proc_sel", proc_sel, 0);
    chk("nom_chirp_idx", chirp_idx, 1);
    chk("nom_wr_sel", wr_sel, 1);
    chk("nom_wr_addr", wr_addr, 0);
    chk("nom_cap_idle", capture_en, 0);
    drive(0, 0, 0, 0);
    chk("nom_proc_start_pulse", proc_start, 0);
    chk("nom_busy_after", busy, 1);

    // Full frame, start pulse while busy is ignored
    do_reset();
    arm();
    for (int i = 0; i < CPF; i++) begin
      chirp(0, "frm", 0);
      drive(0, 0, 0, 0);
      chk("frm_proc_start", proc_start, 1);
      chk("frm_proc_sel", proc_sel, i % 2);
      chk("frm_chirp_idx", chirp_idx, i + 1);
      chk("frm_frame_done", frame_done, (i == CPF - 1) ? 1 : 0);
      chk("frm_busy", busy, (i == CPF - 1) ? 0 : 1);
      drive((i == 0) ? 1'b1 : 1'b0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("frm_chirp_idx_hold", chirp_idx, i + 1);
      chk("frm_frame_done_pulse", frame_done, 0);
    end
    chk("frm_busy_end", busy, 0);
    chk("frm_overrun", overrun, 0);

    // Overrun: FFT holds half 0, half 1 full, third ramp dropped
    do_reset();
    arm();
    chirp(0, "ovr1", 0);
    drive(0, 0, 0, 0);
    chk("ovr_proc_start1", proc_start, 1);
    chirp(0, "ovr2", 0);
    drive(0, 0, 0, 0);
    chk("ovr_no_proc_start", proc_start, 0);
    chk("ovr_chirp_idx2", chirp_idx, 2);
    chk("ovr_flag_before", overrun, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("ovr_flag", overrun, 1);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 0, 0);
      chk("ovr_cap_en", capture_en, 0);
    end
    chk("ovr_chirp_idx_stay", chirp_idx, 2);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("ovr_release_start", proc_start, 1);
    chk("ovr_release_sel", proc_sel, 1);
    chk("ovr_sticky", overrun, 1);

    // Short chirp: ramp restarts after 4 captured samples
    do_reset();
    arm();
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0);
      chk("shc_pre_cap_en", capture_en, 1);
      chk("shc_pre_wr_addr", wr_addr, k);
    end
    drive(0, 0, 1, 0);
    chk("shc_ramp_cap_en", capture_en, 0);
    drive(0, 0, 0, 0);
    chk("shc_flag", short_chirp, 1);
    chk("shc_wr_addr", wr_addr, 0);
    chk("shc_chirp_idx", chirp_idx, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 0, 0);
      chk("shc_cap_en", capture_en, (k >= 3) ? 1 : 0);
      if (k >= 3) chk("shc_wr_addr_run", wr_addr, k - 3);
    end
    drive(0, 0, 0, 0);
    chk("shc_proc_start", proc_start, 1);
    chk("shc_proc_sel", proc_sel, 0);
    chk("shc_chirp_idx_done", chirp_idx, 1);

    // proc_done coincides with completion of chirp 2
    do_reset();
    arm();
    chirp(0, "sim1", 0);
    drive(0, 0, 0, 0);
    chk("sim_proc_start1", proc_start, 1);
    chirp(1, "sim2", 0);
    drive(0, 0, 0, 0);
    chk("sim_proc_start2", proc_start, 1);
    chk("sim_proc_sel2", proc_sel, 1);
    chk("sim_overrun", overrun, 0);
    chk("sim_chirp_idx", chirp_idx, 2);
    chirp(0, "sim3", 1);
    drive(0, 0, 0, 0);
    chk("sim_frame_done", frame_done, 1);
    chk("sim_no_proc_start3", proc_start, 0);
    chk("sim_overrun3", overrun, 0);

    // Ramp watchdog (or indefinite wait without it)
    do_reset();
    arm();
    for (int c = 0; c < 41; c++) drive(0, 0, 0, 0);
`ifdef CHIRP_SEQ_TIMEOUT_EN
    chk("to_before", ramp_timeout, 0);
`endif
    for (int c = 0; c < 20; c++) drive(0, 0, 0, 0);
`ifdef CHIRP_SEQ_TIMEOUT_EN
    chk("to_flag", ramp_timeout, 1);
`endif
    chk("to_busy", busy, 1);
    chirp(0, "to", 1);
    drive(0, 0, 0, 0);
    chk("to_proc_start", proc_start, 1);
    chk("to_chirp_idx", chirp_idx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
